// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, ALU opcodes and the ID/EX control bundle.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned ALU_CTL_W  = 4;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTL_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } idex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Forward-select for one ALU operand: EX/MEM beats MEM/WB beats captured data;
// register 0 is never forwarded.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] captured,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] fwd_data_c
);

  always_comb begin
    fwd_data_c = captured;
    if (src != '0) begin
      if (exmem_reg_write && (exmem_rd == src)) begin
        fwd_data_c = exmem_result;
      end else if (memwb_reg_write && (memwb_rd == src)) begin
        fwd_data_c = memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass at capture, EX-side operand
// forwarding, load-use bubble insertion, flush and hold.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [3:0]        id_alu_control,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_out,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [3:0]        ALU_Control,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data
);

  idex_ctrl_t               ctrl_q;
  idex_ctrl_t               ctrl_d;
  logic [ALU_CTL_W-1:0]     alu_control_q;
  logic [REG_AW-1:0]        rs_q;
  logic [REG_AW-1:0]        rt_q;
  logic [DATA_W-1:0]        rs_data_q;
  logic [DATA_W-1:0]        rt_data_q;
  logic [DATA_W-1:0]        imm_q;

  logic [DATA_W-1:0]        rs_cap_c;
  logic [DATA_W-1:0]        rt_cap_c;
  logic                     load_use_c;
  logic                     take_bubble_c;
  logic                     take_capture_c;
  logic [DATA_W-1:0]        fwd_rs_c;
  logic [DATA_W-1:0]        fwd_rt_c;

  // Write-back landing in the same cycle as decode is not yet visible in the register file.
  always_comb begin
    rs_cap_c = id_rs_data;
    rt_cap_c = id_rt_data;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs)) begin
      rs_cap_c = memwb_result;
    end
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt)) begin
      rt_cap_c = memwb_result;
    end
  end

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.reg_write  = id_reg_write;
    ctrl_d.mem_read   = id_mem_read;
    ctrl_d.mem_write  = id_mem_write;
    ctrl_d.mem_to_reg = id_mem_to_reg;
    ctrl_d.alu_src    = id_alu_src;
  end

  // rt only matters when it is read as a register operand or as store data.
  always_comb begin
    load_use_c = 1'b0;
    if (ex_valid && ctrl_q.mem_read && (ex_rd != '0) && id_valid) begin
      if ((ex_rd == id_rs) ||
          ((ex_rd == id_rt) && (!id_alu_src || id_mem_write))) begin
        load_use_c = 1'b1;
      end
    end
  end

  always_comb begin
    take_bubble_c  = flush || (!hold && load_use_c);
    take_capture_c = !flush && !hold && !load_use_c;
  end

  assign stall_out = hold | load_use_c;

  // Reset and bubble both clear the whole register; hold is the implicit keep.
  always_ff @(posedge clk) begin
    if (!rst_n || take_bubble_c) begin
      ex_valid      <= 1'b0;
      ctrl_q        <= '0;
      alu_control_q <= ALU_AND;
      rs_q          <= '0;
      rt_q          <= '0;
      ex_rd         <= '0;
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      imm_q         <= '0;
    end else if (take_capture_c) begin
      ex_valid      <= id_valid;
      ctrl_q        <= ctrl_d;
      alu_control_q <= id_alu_control;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      ex_rd         <= id_rd;
      rs_data_q     <= rs_cap_c;
      rt_data_q     <= rt_cap_c;
      imm_q         <= id_imm;
    end
  end

  fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .src             (rs_q),
    .captured        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data_c      (fwd_rs_c)
  );

  fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .src             (rt_q),
    .captured        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data_c      (fwd_rt_c)
  );

  assign ALU_A         = fwd_rs_c;
  assign ALU_B         = ctrl_q.alu_src ? imm_q : fwd_rt_c;
  assign ex_store_data = fwd_rt_c;
  assign ALU_Control   = alu_control_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, $zero, capture bypass,
// load-use bubble, flush over hazard, hold and reset during a stall.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush, hold;
  logic        stall_out;
  logic [31:0] ALU_A, ALU_B;
  logic [3:0]  ALU_Control;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_alu_src      (id_alu_src),
    .id_alu_control  (id_alu_control),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_mem_to_reg   (id_mem_to_reg),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .flush           (flush),
    .hold            (hold),
    .stall_out       (stall_out),
    .ALU_A           (ALU_A),
    .ALU_B           (ALU_B),
    .ALU_Control     (ALU_Control),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_rd           (ex_rd),
    .ex_store_data   (ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_alu_src = 0; id_alu_control = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    flush = 0; hold = 0;
  endtask

  // lw r5 <- mem[r1 + 4]
  task automatic drive_lw();
    clear_inputs();
    id_valid = 1; id_rs = 1; id_rt = 5; id_rd = 5;
    id_rs_data = 32'h100; id_imm = 32'h4; id_alu_src = 1;
    id_alu_control = 4'b0010;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  // add r6 <- r5 + r2
  task automatic drive_add_r5();
    clear_inputs();
    id_valid = 1; id_rs = 5; id_rt = 2; id_rd = 6;
    id_rs_data = 32'h0; id_rt_data = 32'h3;
    id_alu_control = 4'b0010; id_reg_write = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    id_valid = 1; id_rs = 3; id_rd = 7; id_rs_data = 32'h55;
    id_reg_write = 1; id_alu_control = 4'b0110;
    step();
    step();
    n_tests++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg});
    end
    n_tests++;
    if (ALU_Control !== 4'b0000 || ex_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_fields: ALU_Control=%b ex_rd=%0d expected 0000/0", ALU_Control, ex_rd);
    end
    n_tests++;
    if (ALU_A !== 32'h0 || ALU_B !== 32'h0 || ex_store_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: A=%h B=%h sd=%h expected 0", ALU_A, ALU_B, ex_store_data);
    end
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: stall_out=%b expected 0", stall_out);
    end
    rst_n = 1;
    step();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ALU_A !== 32'h55 || ALU_Control !== 4'b0110) begin
      n_fail++;
      $display("FAIL reset_first_capture: valid=%b rd=%0d A=%h ctl=%b expected 1/7/55/0110",
               ex_valid, ex_rd, ALU_A, ALU_Control);
    end
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    id_valid = 1; id_rs = 8; id_rt = 9; id_rd = 10;
    id_rs_data = 32'h99; id_rt_data = 32'h77; id_imm = 32'h1234;
    id_alu_control = 4'b0010; id_reg_write = 1;
    step();
    exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h11;
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h22;
    #1;
    n_tests++;
    if (ALU_A !== 32'h11) begin
      n_fail++;
      $display("FAIL fwd_exmem_wins: ALU_A=%h expected 00000011", ALU_A);
    end
    n_tests++;
    if (ALU_B !== 32'h77) begin
      n_fail++;
      $display("FAIL fwd_b_captured: ALU_B=%h expected 00000077", ALU_B);
    end
    exmem_reg_write = 0;
    #1;
    n_tests++;
    if (ALU_A !== 32'h22) begin
      n_fail++;
      $display("FAIL fwd_memwb: ALU_A=%h expected 00000022", ALU_A);
    end
    memwb_reg_write = 0;
    exmem_reg_write = 1; exmem_rd = 9; exmem_result = 32'h3C;
    #1;
    n_tests++;
    if (ALU_A !== 32'h99 || ALU_B !== 32'h3C || ex_store_data !== 32'h3C) begin
      n_fail++;
      $display("FAIL fwd_rt: A=%h B=%h sd=%h expected 99/3c/3c", ALU_A, ALU_B, ex_store_data);
    end
  endtask

  task automatic test_alu_src_imm();
    clear_inputs();
    id_valid = 1; id_rs = 2; id_rt = 9; id_rd = 4;
    id_rs_data = 32'h5; id_rt_data = 32'h66; id_imm = 32'hFFFF_FFF0;
    id_alu_src = 1; id_mem_write = 1; id_alu_control = 4'b0010;
    step();
    exmem_reg_write = 1; exmem_rd = 9; exmem_result = 32'hD00D;
    #1;
    n_tests++;
    if (ALU_B !== 32'hFFFF_FFF0 || ex_store_data !== 32'hD00D || ex_mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_src_imm: B=%h sd=%h mw=%b expected fffffff0/0000d00d/1",
               ALU_B, ex_store_data, ex_mem_write);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 3;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hEEEE;
    step();
    n_tests++;
    if (ALU_A !== 32'h0 || ex_store_data !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg: A=%h sd=%h expected 0/0", ALU_A, ex_store_data);
    end
  endtask

  task automatic test_capture_bypass();
    clear_inputs();
    id_valid = 1; id_rs = 4; id_rt = 4; id_rd = 12;
    id_rs_data = 32'h1; id_rt_data = 32'h2;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hABCD;
    step();
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    #1;
    n_tests++;
    if (ALU_A !== 32'hABCD || ex_store_data !== 32'hABCD) begin
      n_fail++;
      $display("FAIL capture_bypass: A=%h sd=%h expected abcd/abcd", ALU_A, ex_store_data);
    end
  endtask

  task automatic test_load_use();
    drive_lw();
    #1;
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_no_early_stall: stall_out=%b expected 0", stall_out);
    end
    step();
    drive_add_r5();
    #1;
    n_tests++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: stall_out=%b expected 1", stall_out);
    end
    step();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_bubble: valid=%b rw=%b mr=%b expected 0/0/0", ex_valid, ex_reg_write, ex_mem_read);
    end
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h104;
    #1;
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_one_cycle: stall_out=%b expected 0", stall_out);
    end
    step();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hCAFE;
    #1;
    n_tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ALU_A !== 32'hCAFE || ALU_B !== 32'h3) begin
      n_fail++;
      $display("FAIL lu_add_fwd: valid=%b rd=%0d A=%h B=%h expected 1/6/cafe/3",
               ex_valid, ex_rd, ALU_A, ALU_B);
    end
  endtask

  task automatic test_flush_hazard();
    drive_lw();
    step();
    drive_add_r5();
    flush = 1;
    #1;
    n_tests++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_hz_stall: stall_out=%b expected 1", stall_out);
    end
    step();
    n_tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hz_bubble: valid=%b rw=%b mr=%b expected 0/0/0", ex_valid, ex_reg_write, ex_mem_read);
    end
    flush = 0;
    #1;
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hz_no_second: stall_out=%b expected 0", stall_out);
    end
    step();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL flush_hz_advance: valid=%b rd=%0d expected 1/6", ex_valid, ex_rd);
    end
    // flush alone never stalls
    clear_inputs();
    flush = 1;
    #1;
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_only_stall: stall_out=%b expected 0", stall_out);
    end
    step();
    flush = 0;
  endtask

  task automatic test_hold();
    clear_inputs();
    id_valid = 1; id_rs = 7; id_rt = 8; id_rd = 3;
    id_rs_data = 32'h70; id_rt_data = 32'h80;
    id_alu_control = 4'b0110; id_reg_write = 1;
    step();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs = 5'(11 + i); id_rd = 5'(20 + i);
      id_rs_data = 32'(32'h1000 + i); id_alu_control = 4'b0001;
      #1;
      n_tests++;
      if (stall_out !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stall[%0d]: stall_out=%b expected 1", i, stall_out);
      end
      step();
      n_tests++;
      if (ALU_A !== 32'h70 || ex_rd !== 5'd3 || ALU_Control !== 4'b0110 || ex_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_frozen[%0d]: A=%h rd=%0d ctl=%b v=%b expected 70/3/0110/1",
                 i, ALU_A, ex_rd, ALU_Control, ex_valid);
      end
    end
    hold = 0;
    #1;
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_stall: stall_out=%b expected 0", stall_out);
    end
    step();
    n_tests++;
    if (ALU_A !== 32'h1002 || ex_rd !== 5'd22 || ALU_Control !== 4'b0001) begin
      n_fail++;
      $display("FAIL hold_release_adv: A=%h rd=%0d ctl=%b expected 1002/22/0001",
               ALU_A, ex_rd, ALU_Control);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive_lw();
    step();
    drive_add_r5();
    #1;
    n_tests++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall_pre: stall_out=%b expected 1", stall_out);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    n_tests++;
    if (ex_valid !== 1'b0 || stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall_cleared: valid=%b stall=%b expected 0/0", ex_valid, stall_out);
    end
    step();
    n_tests++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall_capture: valid=%b rd=%0d rw=%b expected 1/6/1", ex_valid, ex_rd, ex_reg_write);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_fwd_priority();
    test_alu_src_imm();
    test_zero_reg();
    test_capture_bypass();
    test_load_use();
    test_flush_hazard();
    test_hold();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
